// File: rtl/ariane_ace.sv
// ACE snoop-channel types shared by snoop initiators and responders.
// Contents:
//   ac_chan_t    - AC channel payload (addr, snoop, prot)
//   cd_chan_t    - CD channel payload (data, last)
//   snoop_req_t  - initiator-driven signals: ac_valid, ac, cr_ready, cd_ready
//   snoop_resp_t - responder-driven signals: ac_ready, cr_valid, cr_resp, cd_valid, cd
//   ACSNOOP code constants used by the snoop initiator and its testbench.
package ariane_ace;

  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [3:0]           snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic       ac_ready;
    logic       cr_valid;
    logic [4:0] cr_resp;
    logic       cd_valid;
    cd_chan_t   cd;
  } snoop_resp_t;

  localparam logic [3:0] SnoopReadOnce    = 4'b0000;
  localparam logic [3:0] SnoopReadShared  = 4'b0001;
  localparam logic [3:0] SnoopCleanInvalid = 4'b1001;

endpackage

// File: rtl/std_cache_pkg.sv
// Cache-coherency constants shared by the CCU blocks.
// Contents:
//   CR_* - bit positions within the 5-bit CRRESP field
//   snoop_state_e - state encoding of the snoop initiator FSM
package std_cache_pkg;

  localparam int unsigned CR_DATA_TRANSFER = 0;
  localparam int unsigned CR_ERROR         = 1;
  localparam int unsigned CR_PASS_DIRTY    = 2;
  localparam int unsigned CR_IS_SHARED     = 3;
  localparam int unsigned CR_WAS_UNIQUE    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SEND_AC,
    WAIT_CR,
    RECV_CD,
    RESP
  } snoop_state_e;

endpackage

// File: rtl/ccu_cd_collector.sv
// Collects CD beats into one cache line and checks the CD.last framing.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   clear_i        - start of a new command: zero line, beat counter, error
//   en_i           - CD phase active (beats are accepted only while set)
//   beat_valid_i   - CD beat present
//   beat_data_i    - CD beat payload, written to slot beat_cnt
//   beat_last_i    - CD.last of the current beat
//   done_o         - current beat terminates the CD phase
//   err_o          - sticky framing error (last early, or missing on final beat)
//   line_o         - assembled line, beat 0 in the LSBs
module ccu_cd_collector #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LineWidth = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic                 beat_valid_i,
  input  logic [DataWidth-1:0] beat_data_i,
  input  logic                 beat_last_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LineWidth-1:0] line_o
);

  localparam int unsigned NumBeats = LineWidth / DataWidth;
  localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;

  logic [CntW-1:0]      beat_cnt_q;
  logic [LineWidth-1:0] line_q;
  logic                 err_q;
  logic                 beat_fire;
  logic                 final_beat;

  assign beat_fire  = en_i & beat_valid_i;
  assign final_beat = (beat_cnt_q == CntW'(NumBeats - 1));
  // The phase ends on whichever comes first: CD.last or the slot count.
  assign done_o     = beat_fire & (beat_last_i | final_beat);
  assign err_o      = err_q;
  assign line_o     = line_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
    end else if (clear_i) begin
      beat_cnt_q <= '0;
      line_q     <= '0;
      err_q      <= 1'b0;
    end else if (beat_fire) begin
      line_q[32'(beat_cnt_q) * DataWidth +: DataWidth] <= beat_data_i;
      beat_cnt_q <= final_beat ? '0 : beat_cnt_q + 1'b1;
      if (beat_last_i != final_beat) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccu_snoop_initiator.sv
// Issues one ACE snoop (AC), collects its CR response and optional CD line,
// and returns the result through a valid/ready handshake. One command at a time.
// Optional feature: define SNOOP_TIMEOUT_EN to bound the CR/CD wait by
// TimeoutCycles (timeout -> response with rsp_err_o=1, rsp_crresp_o=0).
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  - snoop command handshake
//   req_addr_i, req_snoop_i    - line address (offset bits ignored), ACSNOOP
//   snoop_req_o / snoop_resp_i - ACE snoop channels (AC, CR, CD)
//   rsp_valid_o / rsp_ready_i  - result handshake
//   rsp_crresp_o, rsp_data_o   - captured CRRESP, assembled line
//   rsp_err_o                  - CRRESP.Error, CD framing error or timeout
module ccu_snoop_initiator
  import ariane_ace::*;
  import std_cache_pkg::*;
#(
  parameter int unsigned AxiDataWidth  = 64,
  parameter int unsigned LineWidth     = 128,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [63:0]          req_addr_i,
  input  logic [3:0]           req_snoop_i,
  output snoop_req_t           snoop_req_o,
  input  snoop_resp_t          snoop_resp_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [4:0]           rsp_crresp_o,
  output logic [LineWidth-1:0] rsp_data_o,
  output logic                 rsp_err_o
);

  localparam logic [63:0] LineMask = 64'((LineWidth / 8) - 1);

  if ((LineWidth % AxiDataWidth) != 0 || AxiDataWidth != ariane_ace::DataWidth
      || TimeoutCycles == 0) begin : g_bad_cfg
    $error("ccu_snoop_initiator: unsupported parameter combination");
  end

  snoop_state_e         state_q, state_d;
  logic [63:0]          addr_q;
  logic [3:0]           snoop_q;
  logic [4:0]           crresp_q;
  logic                 to_err_q;
  logic                 accept;
  logic                 timeout;
  logic                 to_fire;
  logic                 cd_done;
  logic                 cd_err;
  logic [LineWidth-1:0] line;

  assign accept = (state_q == IDLE) && req_valid_i;

`ifdef SNOOP_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt_q;

  // Fires on the cycle whose closing edge makes TimeoutCycles spent waiting.
  assign timeout = ((state_q == WAIT_CR) || (state_q == RECV_CD))
                   && (to_cnt_q == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (state_d != state_q) begin
      to_cnt_q <= '0;
    end else if ((state_q == WAIT_CR) || (state_q == RECV_CD)) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    to_fire = 1'b0;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = SEND_AC;
      SEND_AC: if (snoop_resp_i.ac_ready) state_d = WAIT_CR;
      WAIT_CR: begin
        if (snoop_resp_i.cr_valid) begin
          state_d = snoop_resp_i.cr_resp[CR_DATA_TRANSFER] ? RECV_CD : RESP;
        end else if (timeout) begin
          state_d = RESP;
          to_fire = 1'b1;
        end
      end
      RECV_CD: begin
        if (cd_done) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d = RESP;
          to_fire = 1'b1;
        end
      end
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      snoop_q  <= '0;
      crresp_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= req_addr_i & ~LineMask;
        snoop_q  <= req_snoop_i;
        crresp_q <= '0;
        to_err_q <= 1'b0;
      end else if (to_fire) begin
        crresp_q <= '0;
        to_err_q <= 1'b1;
      end else if ((state_q == WAIT_CR) && snoop_resp_i.cr_valid) begin
        crresp_q <= snoop_resp_i.cr_resp;
      end
    end
  end

  ccu_cd_collector #(
    .DataWidth (AxiDataWidth),
    .LineWidth (LineWidth)
  ) u_cd_collector (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (accept),
    .en_i         (state_q == RECV_CD),
    .beat_valid_i (snoop_resp_i.cd_valid),
    .beat_data_i  (snoop_resp_i.cd.data[AxiDataWidth-1:0]),
    .beat_last_i  (snoop_resp_i.cd.last),
    .done_o       (cd_done),
    .err_o        (cd_err),
    .line_o       (line)
  );

  always_comb begin
    snoop_req_o          = '0;
    snoop_req_o.ac_valid = (state_q == SEND_AC);
    snoop_req_o.ac.addr  = addr_q;
    snoop_req_o.ac.snoop = snoop_q;
    snoop_req_o.ac.prot  = 3'b000;
    snoop_req_o.cr_ready = (state_q == WAIT_CR);
    snoop_req_o.cd_ready = (state_q == RECV_CD);
  end

  assign req_ready_o  = (state_q == IDLE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_crresp_o = crresp_q;
  assign rsp_data_o   = line;
  assign rsp_err_o    = crresp_q[CR_ERROR] | cd_err | to_err_q;

endmodule
